// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: picks the highest-priority event, strobes CP0, flushes, and holds the redirect PC.
// Commit is combinational with the MEM inputs; the redirect is held in REDIR until fetch_ready_i accepts it.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        valid_M,
    input  logic [31:0] pc_M,
    input  logic        in_delayslot_M,
    input  logic        adel_if_M,
    input  logic        ri_M,
    input  logic        syscall_M,
    input  logic        break_M,
    input  logic        ov_M,
    input  logic        eret_M,
    input  logic        adel_ld_M,
    input  logic        ades_st_M,
    input  logic [31:0] mem_addr_M,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        fetch_ready_i,
    output logic        en_o,
    output logic [31:0] except_type_o,
    output logic [31:0] badvaddr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        newpc_valid_o
);

    localparam logic [31:0] EXC_TYPE_INT  = 32'h1;
    localparam logic [31:0] EXC_TYPE_ADEL = 32'h4;
    localparam logic [31:0] EXC_TYPE_ADES = 32'h5;
    localparam logic [31:0] EXC_TYPE_SYS  = 32'h8;
    localparam logic [31:0] EXC_TYPE_BP   = 32'h9;
    localparam logic [31:0] EXC_TYPE_RI   = 32'hA;
    localparam logic [31:0] EXC_TYPE_OV   = 32'hC;
    localparam logic [31:0] EXC_TYPE_ERET = 32'hE;

    typedef enum logic {IDLE, REDIR} state_t;

    state_t      state_q, state_d;
    logic [5:0]  int_q;
    logic [31:0] newpc_q, newpc_d;
    logic [7:0]  ip;
    logic        int_req;
    logic        hit;
    logic [31:0] code;
    logic [31:0] bad;

    // Timer interrupt (cause[30]) shares the top hardware line, as on MIPS32.
    assign ip      = {int_q[5] | cause_i[30], int_q[4:0], cause_i[9:8]};
    assign int_req = status_i[0] & ~status_i[1] & (|(ip & status_i[15:8]));

    always_comb begin
        hit  = 1'b0;
        code = 32'h0;
        bad  = 32'h0;
        if (!rst && state_q == IDLE && valid_M) begin
            hit = 1'b1;
            if (int_req)        code = EXC_TYPE_INT;
            else if (adel_if_M) begin
                code = EXC_TYPE_ADEL;
                bad  = pc_M;
            end
            else if (ri_M)      code = EXC_TYPE_RI;
            else if (syscall_M) code = EXC_TYPE_SYS;
            else if (break_M)   code = EXC_TYPE_BP;
            else if (ov_M)      code = EXC_TYPE_OV;
            else if (adel_ld_M) begin
                code = EXC_TYPE_ADEL;
                bad  = mem_addr_M;
            end
            else if (ades_st_M) begin
                code = EXC_TYPE_ADES;
                bad  = mem_addr_M;
            end
            else if (eret_M)    code = EXC_TYPE_ERET;
            else                hit  = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        newpc_d = newpc_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = REDIR;
                    newpc_d = (code == EXC_TYPE_ERET) ? epc_i : EXC_VECTOR;
                end
            end
            REDIR: begin
                if (fetch_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            int_q   <= 6'h0;
            newpc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            int_q   <= int_i;
            newpc_q <= newpc_d;
        end
    end

    assign en_o              = hit;
    assign flush_o           = hit;
    assign except_type_o     = code;
    assign badvaddr_o        = bad;
    assign is_in_delayslot_o = in_delayslot_M;
    assign newpc_o           = newpc_q;
    assign newpc_valid_o     = (state_q == REDIR);

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios plus randomized traffic against a priority-table model.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        valid_M, in_delayslot_M;
    logic [31:0] pc_M, mem_addr_M, status_i, cause_i, epc_i;
    logic        adel_if_M, ri_M, syscall_M, break_M, ov_M, eret_M, adel_ld_M, ades_st_M;
    logic        fetch_ready_i;
    logic        en_o, is_in_delayslot_o, flush_o, newpc_valid_o;
    logic [31:0] except_type_o, badvaddr_o, newpc_o;

    int tests = 0;
    int fails = 0;

    bit          m_pending;
    logic [5:0]  m_intq;
    logic [31:0] m_newpc;

    exception_ctrl dut (
        .clk(clk), .rst(rst), .int_i(int_i), .valid_M(valid_M), .pc_M(pc_M),
        .in_delayslot_M(in_delayslot_M), .adel_if_M(adel_if_M), .ri_M(ri_M),
        .syscall_M(syscall_M), .break_M(break_M), .ov_M(ov_M), .eret_M(eret_M),
        .adel_ld_M(adel_ld_M), .ades_st_M(ades_st_M), .mem_addr_M(mem_addr_M),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .fetch_ready_i(fetch_ready_i), .en_o(en_o), .except_type_o(except_type_o),
        .badvaddr_o(badvaddr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .flush_o(flush_o), .newpc_o(newpc_o), .newpc_valid_o(newpc_valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    // Reference: walk a priority table and return the first raised event.
    function automatic void model_eval(output bit hit, output logic [31:0] code,
                                       output logic [31:0] bad, output logic [31:0] tgt);
        logic [7:0]  ip;
        bit          intr;
        bit          flags [9];
        logic [31:0] codes [9];
        ip[1:0] = cause_i[9:8];
        ip[6:2] = m_intq[4:0];
        ip[7]   = m_intq[5] | cause_i[30];
        intr = status_i[0] && !status_i[1] && ((ip & status_i[15:8]) != 8'h0);
        flags[0] = intr;      codes[0] = 32'h1;
        flags[1] = adel_if_M; codes[1] = 32'h4;
        flags[2] = ri_M;      codes[2] = 32'hA;
        flags[3] = syscall_M; codes[3] = 32'h8;
        flags[4] = break_M;   codes[4] = 32'h9;
        flags[5] = ov_M;      codes[5] = 32'hC;
        flags[6] = adel_ld_M; codes[6] = 32'h4;
        flags[7] = ades_st_M; codes[7] = 32'h5;
        flags[8] = eret_M;    codes[8] = 32'hE;
        hit = 0; code = 0; bad = 0; tgt = VEC;
        if (rst || m_pending || !valid_M) return;
        for (int i = 0; i < 9; i++) begin
            if (flags[i]) begin
                hit  = 1;
                code = codes[i];
                bad  = (i == 1) ? pc_M : ((i == 6 || i == 7) ? mem_addr_M : 32'h0);
                tgt  = (i == 8) ? epc_i : VEC;
                break;
            end
        end
    endfunction

    // One clock: update the model at the edge from the inputs held across it.
    task automatic cyc();
        bit h;
        logic [31:0] c, b, t;
        model_eval(h, c, b, t);
        @(posedge clk);
        if (rst) begin
            m_pending = 0; m_intq = 0; m_newpc = 0;
        end else begin
            if (!m_pending && h) begin
                m_pending = 1; m_newpc = t;
            end else if (m_pending && fetch_ready_i) begin
                m_pending = 0;
            end
            m_intq = int_i;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic clear_flags();
        valid_M = 0; adel_if_M = 0; ri_M = 0; syscall_M = 0; break_M = 0;
        ov_M = 0; eret_M = 0; adel_ld_M = 0; ades_st_M = 0; in_delayslot_M = 0;
    endtask

    task automatic accept();
        clear_flags();
        fetch_ready_i = 1;
        cyc();
        fetch_ready_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; int_i = 0; pc_M = 0; mem_addr_M = 0; status_i = 0; cause_i = 0;
        epc_i = 0; fetch_ready_i = 0;
        clear_flags();
        cyc(); cyc();
        tests++;
        if ({en_o, flush_o, newpc_valid_o} !== 3'b000 || except_type_o !== 0 ||
            badvaddr_o !== 0 || newpc_o !== 0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b fl=%b nv=%b ty=%h bv=%h npc=%h expected all 0",
                     en_o, flush_o, newpc_valid_o, except_type_o, badvaddr_o, newpc_o);
        end
        valid_M = 1; syscall_M = 1; #1;
        tests++;
        if (en_o !== 0 || flush_o !== 0) begin
            fails++;
            $display("FAIL reset_forces_quiet: got en=%b fl=%b expected 0 0", en_o, flush_o);
        end
        clear_flags();
        rst = 0; cyc();
        tests++;
        if (en_o !== 0 || newpc_valid_o !== 0) begin
            fails++;
            $display("FAIL release_idle: got en=%b nv=%b expected 0 0", en_o, newpc_valid_o);
        end
    endtask

    task automatic test_syscall();
        valid_M = 1; syscall_M = 1; pc_M = 32'hBFC00100; in_delayslot_M = 1; #1;
        tests++;
        if (en_o !== 1 || except_type_o !== 32'h8 || flush_o !== 1 || is_in_delayslot_o !== 1) begin
            fails++;
            $display("FAIL syscall_commit: got en=%b ty=%h fl=%b ds=%b expected 1 8 1 1",
                     en_o, except_type_o, flush_o, is_in_delayslot_o);
        end
        cyc();
        clear_flags(); #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (newpc_valid_o !== 1 || newpc_o !== VEC) begin
                fails++;
                $display("FAIL syscall_hold%0d: got nv=%b npc=%h expected 1 %h",
                         i, newpc_valid_o, newpc_o, VEC);
            end
            if (i < 3) cyc();
        end
        valid_M = 1; syscall_M = 1; #1;
        tests++;
        if (en_o !== 0) begin
            fails++;
            $display("FAIL redir_ignores_mem: got en=%b expected 0", en_o);
        end
        fetch_ready_i = 1; cyc(); fetch_ready_i = 0;
        clear_flags(); #1;
        tests++;
        if (newpc_valid_o !== 0) begin
            fails++;
            $display("FAIL accept_to_idle: got nv=%b expected 0 (event during accept dropped)", newpc_valid_o);
        end
    endtask

    task automatic test_priority();
        valid_M = 1; ri_M = 1; ov_M = 1; #1;
        tests++;
        if (except_type_o !== 32'hA) begin
            fails++;
            $display("FAIL prio_ri_over_ov: got %h expected 0000000a", except_type_o);
        end
        cyc(); accept();
        valid_M = 1; adel_ld_M = 1; mem_addr_M = 32'h80000003; #1;
        tests++;
        if (except_type_o !== 32'h4 || badvaddr_o !== 32'h80000003) begin
            fails++;
            $display("FAIL load_adel: got ty=%h bv=%h expected 4 80000003", except_type_o, badvaddr_o);
        end
        cyc(); accept();
    endtask

    task automatic test_back_to_back();
        valid_M = 1; break_M = 1; #1;
        cyc();
        clear_flags(); fetch_ready_i = 1; cyc(); fetch_ready_i = 0;
        valid_M = 1; ov_M = 1; #1;
        tests++;
        if (en_o !== 1 || except_type_o !== 32'hC) begin
            fails++;
            $display("FAIL back_to_back: got en=%b ty=%h expected 1 c", en_o, except_type_o);
        end
        cyc(); accept();
    endtask

    task automatic test_interrupt();
        status_i = 32'h0000FF01; int_i = 6'b000100; valid_M = 1; #1;
        tests++;
        if (en_o !== 0) begin
            fails++;
            $display("FAIL int_latency: got en=%b expected 0 before int_q registers", en_o);
        end
        cyc();
        tests++;
        if (en_o !== 1 || except_type_o !== 32'h1) begin
            fails++;
            $display("FAIL int_commit: got en=%b ty=%h expected 1 1", en_o, except_type_o);
        end
        cyc(); accept();
        status_i = 32'h0000FF03; valid_M = 1; #1;
        tests++;
        if (en_o !== 0) begin
            fails++;
            $display("FAIL int_exl_masked: got en=%b expected 0", en_o);
        end
        int_i = 0; status_i = 0; clear_flags(); cyc();
    endtask

    task automatic test_eret();
        valid_M = 1; eret_M = 1; epc_i = 32'hBFC00200; #1;
        tests++;
        if (except_type_o !== 32'hE) begin
            fails++;
            $display("FAIL eret_type: got %h expected e", except_type_o);
        end
        cyc(); clear_flags(); #1;
        tests++;
        if (newpc_o !== 32'hBFC00200 || newpc_valid_o !== 1) begin
            fails++;
            $display("FAIL eret_newpc: got npc=%h nv=%b expected bfc00200 1", newpc_o, newpc_valid_o);
        end
        accept();
    endtask

    task automatic test_suppress();
        valid_M = 0; ov_M = 1; #1;
        tests++;
        if (en_o !== 0) begin
            fails++;
            $display("FAIL bubble_suppress: got en=%b expected 0", en_o);
        end
        valid_M = 1; cyc(); clear_flags();
        rst = 1; cyc(); rst = 0; #1;
        tests++;
        if (newpc_valid_o !== 0 || newpc_o !== 0) begin
            fails++;
            $display("FAIL reset_in_redir: got nv=%b npc=%h expected 0 0", newpc_valid_o, newpc_o);
        end
    endtask

    task automatic test_random();
        bit h;
        logic [31:0] c, b, t;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            valid_M = ($urandom_range(0, 3) != 0);
            pc_M = $urandom; mem_addr_M = $urandom; epc_i = $urandom;
            in_delayslot_M = $urandom_range(0, 1);
            adel_if_M = ($urandom_range(0, 7) == 0); ri_M      = ($urandom_range(0, 7) == 0);
            syscall_M = ($urandom_range(0, 7) == 0); break_M   = ($urandom_range(0, 7) == 0);
            ov_M      = ($urandom_range(0, 7) == 0); eret_M    = ($urandom_range(0, 5) == 0);
            adel_ld_M = ($urandom_range(0, 7) == 0); ades_st_M = ($urandom_range(0, 7) == 0);
            int_i = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h0;
            status_i = $urandom; cause_i = $urandom;
            fetch_ready_i = $urandom_range(0, 1);
            #1;
            model_eval(h, c, b, t);
            tests++;
            if (en_o !== h || flush_o !== h || except_type_o !== c ||
                newpc_valid_o !== m_pending || is_in_delayslot_o !== in_delayslot_M ||
                (m_pending && newpc_o !== m_newpc) || (h && badvaddr_o !== b)) begin
                fails++;
                $display("FAIL random_%0d: got en=%b fl=%b ty=%h bv=%h nv=%b npc=%h expected en=%b ty=%h bv=%h nv=%b npc=%h",
                         n, en_o, flush_o, except_type_o, badvaddr_o, newpc_valid_o, newpc_o,
                         h, c, b, m_pending, m_newpc);
            end
            cyc();
        end
        rst = 0;
    endtask

    initial begin
        m_pending = 0; m_intq = 0; m_newpc = 0;
        rst = 1; fetch_ready_i = 0; int_i = 0;
        clear_flags();
        @(negedge clk);
        test_reset();
        test_syscall();
        test_priority();
        test_back_to_back();
        test_interrupt();
        test_eret();
        test_suppress();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
